serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first,
// start/ready load and valid/ack result handshake. Define SERIAL_SUB_OVF_EN to add o_ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_valid,
    input  logic             i_ack
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_subtractor: WIDTH must be at least 2");
        end
    endgenerate

    // Full-subtractor cell: difference bit.
    function automatic logic fs_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    // Full-subtractor cell: borrow out.
    function automatic logic fs_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   diff_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               load_s;
    logic               shift_s;
    logic               last_s;
    logic               d_s;
    logic               br_next_s;

    assign d_s       = fs_diff(a_sr_r[0], b_sr_r[0], borrow_r);
    assign br_next_s = fs_borrow(a_sr_r[0], b_sr_r[0], borrow_r);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    last_s       = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (i_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers, result register, borrow and bit counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (load_s) begin
            a_sr_r   <= i_a;
            b_sr_r   <= i_b;
            borrow_r <= i_bin;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (shift_s) begin
            a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
            diff_r   <= {d_s, diff_r[WIDTH-1:1]};
            borrow_r <= br_next_s;
            // Counter parks on the last bit instead of wrapping.
            if (!last_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_r;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_r <= 1'b0;
        end else if (shift_s && last_s) begin
            ovf_r <= borrow_r ^ br_next_s;
        end
    end

    assign o_ovf = ovf_r;
`endif

    assign o_ready = (state_r == ST_IDLE);
    assign o_valid = (state_r == ST_DONE);
    assign o_diff  = diff_r;
    assign o_bout  = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;
    logic             o_valid;
    logic             i_ack;
`ifdef SERIAL_SUB_OVF_EN
    logic             o_ovf;
`endif

    int total;
    int bad;
    int cyc;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_bin   (i_bin),
        .o_diff  (o_diff),
        .o_bout  (o_bout),
        .o_valid (o_valid),
        .i_ack   (i_ack)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        i_a     = a;
        i_b     = b;
        i_bin   = bin;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic send_ack;
        i_ack = 1'b1;
        @(posedge i_clk);
        #1;
        i_ack = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        total++; if (o_diff !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h exp=00", o_diff); end
        total++; if (o_bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b exp=0", o_bout); end
`ifdef SERIAL_SUB_OVF_EN
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
`endif
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_basic;
        int lat;
        start_op(8'h05, 8'h03, 1'b0);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_fall got=%b exp=0", o_ready); end
        wait_valid(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        total++; if (o_diff !== 8'h02) begin bad++; $display("FAIL basic_diff got=%h exp=02", o_diff); end
        total++; if (o_bout !== 1'b0) begin bad++; $display("FAIL basic_bout got=%b exp=0", o_bout); end
`ifdef SERIAL_SUB_OVF_EN
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", o_ovf); end
`endif
        send_ack;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL basic_ack_ready got=%b exp=1", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_valid got=%b exp=0", o_valid); end
    endtask

    task automatic test_borrow_out;
        int lat;
        start_op(8'h03, 8'h05, 1'b0);
        wait_valid(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL borrow1_latency got=%0d exp=8", lat); end
        total++; if (o_diff !== 8'hFE) begin bad++; $display("FAIL borrow1_diff got=%h exp=fe", o_diff); end
        total++; if (o_bout !== 1'b1) begin bad++; $display("FAIL borrow1_bout got=%b exp=1", o_bout); end
`ifdef SERIAL_SUB_OVF_EN
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL borrow1_ovf got=%b exp=0", o_ovf); end
`endif
        send_ack;
        start_op(8'h00, 8'h00, 1'b1);
        wait_valid(lat);
        total++; if (o_diff !== 8'hFF) begin bad++; $display("FAIL borrow2_diff got=%h exp=ff", o_diff); end
        total++; if (o_bout !== 1'b1) begin bad++; $display("FAIL borrow2_bout got=%b exp=1", o_bout); end
        send_ack;
    endtask

    task automatic test_overflow;
        int lat;
        start_op(8'h80, 8'h01, 1'b0);
        wait_valid(lat);
        total++; if (o_diff !== 8'h7F) begin bad++; $display("FAIL ovf_diff got=%h exp=7f", o_diff); end
        total++; if (o_bout !== 1'b0) begin bad++; $display("FAIL ovf_bout got=%b exp=0", o_bout); end
`ifdef SERIAL_SUB_OVF_EN
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", o_ovf); end
`endif
        send_ack;
    endtask

    task automatic test_handshake;
        int lat;
        start_op(8'h33, 8'h11, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            i_start = i[0];
            i_a     = 8'hFF;
            @(posedge i_clk);
            #1;
            total++;
            if (o_valid !== (i == 8)) begin bad++; $display("FAIL hs_shift_valid cyc=%0d got=%b", i, o_valid); end
        end
        for (int i = 0; i < 20; i++) begin
            i_start = ~i_start;
            @(posedge i_clk);
            #1;
            total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL hs_hold_valid cyc=%0d got=%b exp=1", i, o_valid); end
            total++; if (o_diff !== 8'h22) begin bad++; $display("FAIL hs_hold_diff cyc=%0d got=%h exp=22", i, o_diff); end
        end
        i_start = 1'b0;
        send_ack;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL hs_ready got=%b exp=1", o_ready); end
        start_op(8'h40, 8'h01, 1'b1);
        wait_valid(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL hs_new_latency got=%0d exp=8", lat); end
        total++; if (o_diff !== 8'h3E) begin bad++; $display("FAIL hs_new_diff got=%h exp=3e", o_diff); end
        send_ack;
    endtask

    task automatic test_operand_stability;
        start_op(8'h5A, 8'h33, 1'b0);
        for (int i = 0; i < 8; i++) begin
            i_a   = 8'($urandom_range(0, 255));
            i_b   = 8'($urandom_range(0, 255));
            i_bin = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            #1;
        end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stab_valid got=%b exp=1", o_valid); end
        total++; if (o_diff !== 8'h27) begin bad++; $display("FAIL stab_diff got=%h exp=27", o_diff); end
        total++; if (o_bout !== 1'b0) begin bad++; $display("FAIL stab_bout got=%b exp=0", o_bout); end
        send_ack;
    endtask

    task automatic test_reset_mid_op;
        int lat;
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (4) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", o_valid); end
        total++; if (o_diff !== 8'h00) begin bad++; $display("FAIL rst_mid_diff got=%h exp=00", o_diff); end
        total++; if (o_bout !== 1'b0) begin bad++; $display("FAIL rst_mid_bout got=%b exp=0", o_bout); end
`ifdef SERIAL_SUB_OVF_EN
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL rst_mid_ovf got=%b exp=0", o_ovf); end
`endif
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got=%b exp=1", o_ready); end
        start_op(8'h10, 8'h01, 1'b0);
        wait_valid(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL rst_after_latency got=%0d exp=8", lat); end
        total++; if (o_diff !== 8'h0F) begin bad++; $display("FAIL rst_after_diff got=%h exp=0f", o_diff); end
        send_ack;
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h7F, 8'hC8};
        logic [7:0] vb [4] = '{8'hFF, 8'h00, 8'hFF, 8'h64};
        logic       vi [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ed [4] = '{8'h01, 8'hFE, 8'h80, 8'h64};
        logic       eb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        int prev_acc;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            start_op(va[k], vb[k], vi[k]);
            if (k > 0) begin
                total++;
                if (cyc - prev_acc !== WIDTH + 2) begin bad++; $display("FAIL b2b_period op=%0d got=%0d exp=%0d", k, cyc - prev_acc, WIDTH + 2); end
            end
            prev_acc = cyc;
            wait_valid(lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL b2b_latency op=%0d got=%0d exp=8", k, lat); end
            total++; if (o_diff !== ed[k]) begin bad++; $display("FAIL b2b_diff op=%0d got=%h exp=%h", k, o_diff, ed[k]); end
            total++; if (o_bout !== eb[k]) begin bad++; $display("FAIL b2b_bout op=%0d got=%b exp=%b", k, o_bout, eb[k]); end
`ifdef SERIAL_SUB_OVF_EN
            total++; if (o_ovf !== eo[k]) begin bad++; $display("FAIL b2b_ovf op=%0d got=%b exp=%b", k, o_ovf, eo[k]); end
`else
            if (eo[k] === 1'bx) $display("unexpected x in ovf table");
`endif
            send_ack;
            total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready op=%0d got=%b exp=1", k, o_ready); end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_ack   = 1'b0;
        i_a     = 8'h00;
        i_b     = 8'h00;
        i_bin   = 1'b0;
        test_reset;
        test_basic;
        test_borrow_out;
        test_overflow;
        test_handshake;
        test_operand_stability;
        test_reset_mid_op;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
